// File: rtl/syscall_pkg.sv
// ----------------------------------------------------------------------------
// syscall_pkg : shared syscall codes, print-entry kinds and FSM states
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package syscall_pkg;

  localparam int SYS_PRINT_INT  = 1;
  localparam int SYS_EXIT       = 10;
  localparam int SYS_PRINT_CHAR = 11;
  localparam int SYS_EXIT2      = 17;

  localparam logic KIND_INT  = 1'b0;
  localparam logic KIND_CHAR = 1'b1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/syscall_fifo.sv
// ----------------------------------------------------------------------------
// syscall_fifo : print buffer with registered occupancy and valid/ready read side
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module syscall_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_push_data,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_rd_data,
  output logic [$clog2(DEPTH+1)-1:0]     o_count,
  output logic                           o_full,
  output logic                           o_empty
);

  import syscall_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_push;
  logic w_pop;

  // Guards use the registered occupancy only, so a pop never frees room for a same-cycle push when full.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

  // Read data is forced to zero when empty so outputs are clean after reset.
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/syscall_unit.sv
// ----------------------------------------------------------------------------
// syscall_unit : clocked MIPS syscall handler with buffered console output
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module syscall_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             syscall_valid,
  input  logic             instr_retire,
  input  logic [XLEN-1:0]  v0,
  input  logic [XLEN-1:0]  a0,
  output logic             stall,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_kind,
  output logic [XLEN-1:0]  out_data,
  output logic             halt,
  output logic [7:0]       exit_code,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  import syscall_pkg::*;

  localparam int CW = $clog2(DEPTH+1);

  state_t           r_state;
  logic [7:0]       r_exit_code;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_instr_count;

  logic             w_is_pint;
  logic             w_is_pchar;
  logic             w_is_exit;
  logic             w_is_exit2;
  logic             w_is_print;
  logic             w_is_any_exit;
  logic             w_in_run;
  logic             w_push;
  logic             w_pop;
  logic [XLEN:0]    w_push_data;
  logic [XLEN:0]    w_rd_data;
  logic [CW-1:0]    w_count;
  logic             w_full;
  logic             w_empty;

  // Codes are compared over the full register width; any upper bit set makes the code unknown.
  assign w_is_pint     = (v0 == XLEN'(SYS_PRINT_INT));
  assign w_is_pchar    = (v0 == XLEN'(SYS_PRINT_CHAR));
  assign w_is_exit     = (v0 == XLEN'(SYS_EXIT));
  assign w_is_exit2    = (v0 == XLEN'(SYS_EXIT2));
  assign w_is_print    = w_is_pint | w_is_pchar;
  assign w_is_any_exit = w_is_exit | w_is_exit2;
  assign w_in_run      = (r_state == RUN);

  assign w_push      = w_in_run & syscall_valid & w_is_print & ~w_full;
  assign w_push_data = w_is_pchar ? {KIND_CHAR, {(XLEN-8){1'b0}}, a0[7:0]}
                                  : {KIND_INT, a0};
  assign w_pop       = out_valid & out_ready;

  syscall_fifo #(
    .WIDTH (XLEN + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_rd_data   (w_rd_data),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign out_valid   = ~w_empty;
  assign out_kind    = w_rd_data[XLEN];
  assign out_data    = w_rd_data[XLEN-1:0];
  assign halt        = (r_state == HALTED);
  assign exit_code   = r_exit_code;
  assign illegal     = r_illegal;
  assign cycle_count = r_cycle_count;
  assign instr_count = r_instr_count;

  // An exit stalls in the cycle it is seen so the CPU never commits past it.
  assign stall = ~w_in_run
               | (syscall_valid & (w_is_any_exit | (w_is_print & w_full)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RUN;
      r_exit_code   <= 8'd0;
      r_illegal     <= 1'b0;
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (syscall_valid) begin
            if (w_is_any_exit) begin
              r_exit_code <= w_is_exit2 ? a0[7:0] : 8'd0;
              r_state     <= DRAIN;
            end else if (!w_is_print) begin
              r_illegal <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (w_count == '0) begin
            r_state <= HALTED;
          end
        end
        default: r_state <= HALTED;
      endcase

      if ((r_state != HALTED) && (r_cycle_count != '1)) begin
        r_cycle_count <= r_cycle_count + CNT_W'(1);
      end
      if (w_in_run && instr_retire && (r_instr_count != '1)) begin
        r_instr_count <= r_instr_count + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/syscall_unit.md
Name: syscall_unit

Overview:
- Clocked, parametrised successor to the combinational system-call handler. Sits beside the register file/commit stage and executes MIPS syscalls (print int, print char, exit, exit2).
- Print requests are buffered in a FIFO and drained to the console/testbench over a valid/ready port. The CPU is stalled when the buffer is full.
- Exit drains pending output, then raises halt with an exit code.
- Cycle and retired-instruction counters are exposed in hardware instead of $display.

Parameters:
XLEN, 32, width of v0/a0/out_data
DEPTH, 4, print FIFO entries; power of 2, >= 2
CNT_W, 32, width of cycle/instruction counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
syscall_valid  input  1  syscall instruction is at commit this cycle; held by CPU while stall=1
instr_retire  input  1  one instruction retires this cycle
v0  input  XLEN  syscall code
a0  input  XLEN  syscall argument
stall  output  1  CPU must hold current instruction
out_valid  output  1  print entry available
out_ready  input  1  consumer accepts entry
out_kind  output  1  0 = integer, 1 = char
out_data  output  XLEN  value to print; char kind uses bits [7:0], upper bits zero
halt  output  1  program has exited; sticky
exit_code  output  8  0 for code 10, a0[7:0] for code 17
illegal  output  1  sticky: unknown syscall code seen
cycle_count  output  CNT_W  cycles spent in RUN and DRAIN
instr_count  output  CNT_W  instructions retired in RUN

Behaviour:
- Reset (async): state=RUN, FIFO empty, stall=0, out_valid=0, out_kind=0, out_data=0, halt=0, exit_code=0, illegal=0, counters=0. Reset mid-drain discards all FIFO contents.
- States:
  - RUN, syscall_valid with v0=1 or 11:
    - If registered count<DEPTH: push {kind,a0}; stall=0.
    - Else: stall=1 (combinational), no push.
    - No bypass: a pop in the same cycle does not admit a push while full.
  - RUN, syscall_valid with v0=10 or 17: latch exit_code; go to DRAIN next cycle; stall=1 in that same cycle and every cycle thereafter.
  - RUN, syscall_valid with any other v0: set illegal; no push; stall=0; continue.
  - DRAIN: syscall_valid ignored; stall=1. Go to HALTED in the cycle after the FIFO becomes empty (out_valid=0).
  - HALTED: halt=1, stall=1, all counters frozen. Only rst exits this state.
- FIFO:
  - Push-to-out_valid latency is 1 cycle.
  - Pop occurs when out_valid & out_ready.
  - Simultaneous push and pop when not full: count unchanged, order preserved.
  - Pointers wrap modulo DEPTH.
  - out_data/out_kind are stable while out_valid=1 and out_ready=0.
- Counters:
  - cycle_count increments every clock in RUN and DRAIN.
  - instr_count increments when instr_retire=1 in RUN only.
  - Both saturate at 2^CNT_W-1 (no wrap).
- v0 is compared over its full XLEN width; upper bits set means illegal.

Decomposition:
- Package syscall_pkg:
  - Codes SYS_PRINT_INT=1, SYS_EXIT=10, SYS_PRINT_CHAR=11, SYS_EXIT2=17.
  - Kind constants KIND_INT=0, KIND_CHAR=1.
  - State enum {RUN, DRAIN, HALTED}.
- Sub-module syscall_fifo (parametrised WIDTH, DEPTH):
  - Outputs count/full/empty, using registered count.
  - Push/pop with valid/ready on the read side.

Test Plan:
- Reset, then v0=1, a0=42 with syscall_valid for 1 cycle, out_ready=1 -> next cycle out_valid=1, out_kind=0, out_data=42; one cycle later out_valid=0; stall never asserted.
- out_ready=0; issue 5 print syscalls (a0=1..5) with DEPTH=4 -> first 4 accepted, stall=1 on the 5th. Raise out_ready -> stall drops the cycle after the first pop; output order 1,2,3,4,5.
- With 3 entries queued and out_ready=0, issue v0=17, a0=0x1FF -> exit_code=0xFF, state DRAIN, stall=1, halt=0. Release out_ready -> 3 entries drain, halt=1 the cycle after empty; cycle_count then frozen.
- v0=11, a0=0x12345641 -> out_kind=1, out_data=0x41. Then v0=99 -> illegal=1 and stays 1; no FIFO entry.
- CNT_W=4, hold instr_retire=1 for 20 cycles in RUN -> instr_count and cycle_count stop at 15.
- Assert rst asynchronously mid-DRAIN with 2 entries queued -> outputs zero immediately; after release, state RUN and FIFO empty.
